// File: rtl/axil_reg_bank_if.sv
// AXI-lite bus bundle carried between an AXI-lite master and the axil_reg_bank slave.
interface axil_reg_bank_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_bank.sv
// AXI-lite slave register bank with byte-strobe writes, read-only status slots and SLVERR on out-of-range.
// Optional AXIL_REG_BANK_WRITE_PULSE_EN adds a one-cycle per-register write strobe output.
module axil_reg_bank #(
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int                    REG_COUNT      = 16,
  parameter logic [REG_COUNT-1:0]  READ_ONLY_MASK = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  axil_reg_bank_if.slave                  s_axil,
  output logic [REG_COUNT*DATA_WIDTH-1:0] reg_out,
  input  logic [REG_COUNT*DATA_WIDTH-1:0] reg_in
`ifdef AXIL_REG_BANK_WRITE_PULSE_EN
  ,
  output logic [REG_COUNT-1:0]            reg_wr_pulse
`endif
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic [IDX_W-1:0]      w_wr_idx;
  logic [IDX_W-1:0]      w_rd_idx;
  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic                  w_wr_hs;
  logic                  w_rd_hs;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_unused;

  assign w_wr_idx      = s_axil.awaddr[ADDR_WIDTH-1:ADDR_LSB];
  assign w_rd_idx      = s_axil.araddr[ADDR_WIDTH-1:ADDR_LSB];
  assign w_wr_in_range = 32'(w_wr_idx) < REG_COUNT;
  assign w_rd_in_range = 32'(w_rd_idx) < REG_COUNT;

  // AW and W are only ever taken together; a pending B beat blocks unless it drains this cycle.
  assign w_wr_hs = s_axil.awvalid && s_axil.wvalid && (!r_bvalid || s_axil.bready);
  assign w_rd_hs = s_axil.arvalid && (!r_rvalid || s_axil.rready);

  assign s_axil.awready = w_wr_hs;
  assign s_axil.wready  = w_wr_hs;
  assign s_axil.arready = w_rd_hs;
  assign s_axil.bvalid  = r_bvalid;
  assign s_axil.bresp   = r_bresp;
  assign s_axil.rvalid  = r_rvalid;
  assign s_axil.rdata   = r_rdata;
  assign s_axil.rresp   = r_rresp;

  assign w_unused = ^{s_axil.awprot, s_axil.arprot,
                      s_axil.awaddr[ADDR_LSB-1:0], s_axil.araddr[ADDR_LSB-1:0], reg_in};

  // Read-only slots keep their reset zero forever so reg_out exports 0 there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= READ_ONLY_MASK[i] ? '0 : RESET_VALUE;
      end
    end else if (w_wr_hs) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        if (!READ_ONLY_MASK[i] && (32'(w_wr_idx) == i)) begin
          for (int unsigned k = 0; k < STRB_WIDTH; k++) begin
            if (s_axil.wstrb[k]) begin
              r_regs[i][k*8 +: 8] <= s_axil.wdata[k*8 +: 8];
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

  always_comb begin
    w_rd_data = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      if (32'(w_rd_idx) == i) begin
        w_rd_data = READ_ONLY_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_wr_hs) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axil.bready) begin
      r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_rd_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axil.rready) begin
      r_rvalid <= 1'b0;
    end
  end

`ifdef AXIL_REG_BANK_WRITE_PULSE_EN
  logic [REG_COUNT-1:0] r_wr_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_wr_hs && (|s_axil.wstrb)) begin
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
          if (32'(w_wr_idx) == i) begin
            r_wr_pulse[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign reg_wr_pulse = r_wr_pulse;
`endif

endmodule

// File: doc/axil_reg_bank.md
Name: axil_reg_bank

Overview:
- AXI-lite slave register bank that terminates the AXI-lite master port of the AXI-to-AXI-lite adapter.
- Provides REG_COUNT word-wide control/status registers, with byte-strobe writes, read-only status inputs and error responses for out-of-range addresses.
- Register contents are exported as a flat vector to surrounding logic.

Parameters:
- ADDR_WIDTH, 16, AXI-lite byte address width.
- DATA_WIDTH, 32, register and bus data width (32 or 64).
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- REG_COUNT, 16, number of registers (1..256).
- READ_ONLY_MASK, 0, REG_COUNT-bit mask; bit i set makes register i return reg_in slice i and ignore writes.
- RESET_VALUE, 0, DATA_WIDTH value loaded into every writable register on reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_axil_awaddr  in  ADDR_WIDTH  write address
- s_axil_awprot  in  3  ignored
- s_axil_awvalid  in  1
- s_axil_awready  out  1
- s_axil_wdata  in  DATA_WIDTH
- s_axil_wstrb  in  STRB_WIDTH
- s_axil_wvalid  in  1
- s_axil_wready  out  1
- s_axil_bresp  out  2
- s_axil_bvalid  out  1
- s_axil_bready  in  1
- s_axil_araddr  in  ADDR_WIDTH
- s_axil_arprot  in  3  ignored
- s_axil_arvalid  in  1
- s_axil_arready  out  1
- s_axil_rdata  out  DATA_WIDTH
- s_axil_rresp  out  2
- s_axil_rvalid  out  1
- s_axil_rready  in  1
- reg_out  out  REG_COUNT*DATA_WIDTH  register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- reg_in  in  REG_COUNT*DATA_WIDTH  read-only register sources, same packing

Behaviour:
- Interface: single clock clk; rst is asynchronous, active-high.
- Reset values: every output is 0, except reg_out, whose writable slices hold RESET_VALUE and whose read-only slices are 0. Reset asserted mid-transaction drops the pending B/R beat without a response; the master must reset too.
- Register index: addr[ADDR_WIDTH-1:log2(STRB_WIDTH)]. The low address bits are ignored (unaligned addresses are treated as aligned).
- Write path:
  - awready = wready = awvalid && wvalid && (!bvalid || bready). AW and W are accepted together only.
  - On the handshake in cycle N, each byte k with wstrb[k]=1 of a writable, in-range register is updated at the edge ending cycle N; the new value is visible on reg_out in cycle N+1.
  - bvalid rises in cycle N+1 and holds until bready.
  - bresp: OKAY (2'b00) for in-range registers, including read-only ones (write ignored); SLVERR (2'b10) for index >= REG_COUNT (write dropped).
  - If bvalid && bready coincide with a new handshake, bvalid stays 1 for the new response (back-to-back, one write per cycle).
- Read path:
  - arready = arvalid && (!rvalid || rready).
  - On the handshake in cycle N, rdata is captured from the register value (or the reg_in slice for read-only registers) as it is in cycle N; rvalid rises in cycle N+1.
  - rdata/rresp are stable while rvalid && !rready. Out of range: rdata=0, rresp=SLVERR.
  - One read per cycle sustained when rready is held at 1.
- Simultaneous read and write:
  - The two paths are independent and both handshake in the same cycle.
  - A read of the register being written in that cycle returns the pre-write value.
- wstrb=0 completes with OKAY and no change.
- Implementation: no FSM beyond the two valid flags; flops are bvalid, bresp, rvalid, rdata, rresp and the register array.

Optional Feature:
- Macro: AXIL_REG_BANK_WRITE_PULSE_EN.
- When defined:
  - Adds output reg_wr_pulse (REG_COUNT bits).
  - Bit i is high for exactly one cycle (N+1) after an accepted in-range write to register i with at least one strobe bit set. This includes read-only registers, so hardware can trigger on command writes.
  - Resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- After reset, read addr 0x0 with RESET_VALUE=0xA5A5A5A5 -> rdata=0xA5A5A5A5, rresp=OKAY, rvalid in the cycle after arready.
- Write 0x12345678 strb 0xF to 0x8, then write 0xFFFFFFFF strb 0x2 to 0x8 -> reg_out slice 2 = 0x1234FF78, each bresp=OKAY, bvalid one cycle after the handshake.
- Write to 0x40 with REG_COUNT=16 -> bresp=SLVERR, no reg_out change; read 0x40 -> rdata=0, rresp=SLVERR.
- READ_ONLY_MASK=0x2, reg_in slice 1 = 0xDEADBEEF; write 0x0 to 0x4 -> bresp=OKAY; read 0x4 -> 0xDEADBEEF. With the macro defined, reg_wr_pulse=0x0002 for exactly one cycle.
- Same-cycle write 0x11111111 and read at 0xC (old value 0x0) -> rdata=0x0; next read -> 0x11111111.
- Hold bready=0 after a write while issuing a second AW+W -> awready/wready stay 0 until bready=1, then both accepted with no lost response. Hold rready=0 -> rdata stable and arready=0.
